// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops pairs of words from a fifo_flops-style FIFO and
// presents them as one double-width word with a valid/ready handshake.
// A lone half-packed word can be forced out with flush (upper half zeroed,
// out_partial set). Counts consumed words and completed transfers.
// Optional: define PACKER_PARITY_EN to add out_parity (XOR of out_data).
module fifo_word_packer #(
    parameter int width = 16,
    parameter int cnt_w = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pndng,
    input  logic [width-1:0]     Dout,
    output logic                 pop,
    input  logic                 flush,
    output logic [2*width-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_partial,
    output logic [cnt_w-1:0]     words_popped,
    output logic [cnt_w-1:0]     pkts_sent
`ifdef PACKER_PARITY_EN
   ,output logic                 out_parity
`endif
);

    typedef enum logic [1:0] {EMPTY, HALF, HOLD} state_t;

    state_t             state, state_nxt;
    logic [2*width-1:0] data_nxt;
    logic               partial_nxt;
    logic               xfer;

    assign out_valid = (state == HOLD);
    assign xfer      = out_valid && out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EMPTY;
        else      state <= state_nxt;
    end

    // Next state, pop strobe and next packed word. The low half is kept in
    // out_data[width-1:0] while in HALF so no separate holding register is needed.
    always_comb begin
        state_nxt   = state;
        data_nxt    = out_data;
        partial_nxt = out_partial;
        pop         = 1'b0;
        case (state)
            EMPTY: begin
                if (pndng) begin
                    pop         = 1'b1;
                    data_nxt    = {{width{1'b0}}, Dout};
                    partial_nxt = 1'b0;
                    state_nxt   = HALF;
                end
            end
            HALF: begin
                // A waiting word beats flush: a full packet is preferred.
                if (pndng) begin
                    pop         = 1'b1;
                    data_nxt    = {Dout, out_data[width-1:0]};
                    partial_nxt = 1'b0;
                    state_nxt   = HOLD;
                end else if (flush) begin
                    data_nxt    = {{width{1'b0}}, out_data[width-1:0]};
                    partial_nxt = 1'b1;
                    state_nxt   = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
        // Reset must silence pop immediately, not only after the state clears.
        if (!rst) pop = 1'b0;
    end

    // Packed word and its qualifier; unchanged in HOLD so they stay stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data    <= '0;
            out_partial <= 1'b0;
        end else begin
            out_data    <= data_nxt;
            out_partial <= partial_nxt;
        end
    end

    // Statistics counters, free-running and wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            words_popped <= '0;
            pkts_sent    <= '0;
        end else begin
            if (pop)  words_popped <= words_popped + 1'b1;
            if (xfer) pkts_sent    <= pkts_sent + 1'b1;
        end
    end

`ifdef PACKER_PARITY_EN
    // Parity registered alongside out_data so it tracks the held word exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) out_parity <= 1'b0;
        else      out_parity <= ^data_nxt;
    end
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Testbench for fifo_word_packer: directed vector table, hand-written reset
// and parity sequences, then randomized traffic against a queue-based model.
module tb_fifo_word_packer;

    logic        clk, rst, pndng, pop, flush, out_valid, out_ready, out_partial;
    logic [15:0] Dout, words_popped, pkts_sent;
    logic [31:0] out_data;
`ifdef PACKER_PARITY_EN
    logic        out_parity;
`endif

    int errors = 0;
    int checks = 0;

    fifo_word_packer #(.width(16), .cnt_w(16)) dut (
        .clk(clk), .rst(rst), .pndng(pndng), .Dout(Dout), .pop(pop),
        .flush(flush), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_partial(out_partial),
        .words_popped(words_popped), .pkts_sent(pkts_sent)
`ifdef PACKER_PARITY_EN
       ,.out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pndng;
        logic [15:0] dout;
        logic        flush;
        logic        ready;
        logic        exp_pop;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_partial;
        logic [15:0] exp_words;
        logic [15:0] exp_pkts;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic p, input logic [15:0] d, input logic f, input logic r,
                       input logic ep, input logic ev, input logic [31:0] ed,
                       input logic epa, input logic [15:0] ew, input logic [15:0] ek);
        vec_t v;
        v.pndng = p; v.dout = d; v.flush = f; v.ready = r;
        v.exp_pop = ep; v.exp_valid = ev; v.exp_data = ed; v.exp_partial = epa;
        v.exp_words = ew; v.exp_pkts = ek;
        vecs.push_back(v);
    endtask

    // Drive one row, check pop before the edge and registered outputs after it.
    task automatic apply(input vec_t v, input int idx);
        pndng = v.pndng; Dout = v.dout; flush = v.flush; out_ready = v.ready;
        #1;
        chk($sformatf("vec%0d pop", idx), pop, v.exp_pop);
        @(posedge clk); #1;
        chk($sformatf("vec%0d valid", idx), out_valid, v.exp_valid);
        if (v.exp_valid) begin
            chk($sformatf("vec%0d data", idx), out_data, v.exp_data);
            chk($sformatf("vec%0d partial", idx), out_partial, v.exp_partial);
        end
        chk($sformatf("vec%0d words", idx), words_popped, v.exp_words);
        chk($sformatf("vec%0d pkts", idx), pkts_sent, v.exp_pkts);
    endtask

    // Reference model state: TB-side FIFO contents and a packer viewed as
    // "words collected so far" plus "one packet on offer".
    logic [15:0] fq[$];
    logic [15:0] held[$];
    logic        m_valid, m_partial;
    logic [31:0] m_data;
    logic [15:0] m_words, m_pkts;

    initial begin
        rst = 1'b0; pndng = 1'b1; Dout = 16'hFFFF; flush = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst pop", pop, 1'b0);
        @(posedge clk); #1;
        chk("rst valid", out_valid, 1'b0);
        chk("rst data", out_data, 32'h0);
        chk("rst partial", out_partial, 1'b0);
        chk("rst words", words_popped, 16'h0);
        chk("rst pkts", pkts_sent, 16'h0);
        chk("rst pop held", pop, 1'b0);

        // Two back-to-back pops, flush partial, flush vs pop priority, HOLD stall.
        add(1, 16'hAAAA, 0, 1, 1, 0, 32'h0,          0, 1, 0);
        add(1, 16'h5555, 0, 1, 1, 1, 32'h5555AAAA,   0, 2, 0);
        add(0, 16'h0000, 0, 1, 0, 0, 32'h0,          0, 2, 1);
        add(1, 16'h1234, 0, 0, 1, 0, 32'h0,          0, 3, 1);
        add(0, 16'h0000, 1, 0, 0, 1, 32'h00001234,   1, 3, 1);
        add(0, 16'h0000, 1, 0, 0, 1, 32'h00001234,   1, 3, 1);
        add(0, 16'h0000, 0, 1, 0, 0, 32'h0,          0, 3, 2);
        add(0, 16'h0000, 1, 0, 0, 0, 32'h0,          0, 3, 2);
        add(1, 16'h1111, 0, 1, 1, 0, 32'h0,          0, 4, 2);
        add(1, 16'hBEEF, 1, 1, 1, 1, 32'hBEEF1111,   0, 5, 2);
        add(1, 16'h2222, 0, 1, 0, 0, 32'h0,          0, 5, 3);
        add(1, 16'h2222, 0, 0, 1, 0, 32'h0,          0, 6, 3);
        add(1, 16'h3333, 0, 0, 1, 1, 32'h33332222,   0, 7, 3);
        for (int i = 0; i < 5; i++)
            add(1, 16'h4444, 1, 0, 0, 1, 32'h33332222, 0, 7, 3);
        add(1, 16'h4444, 0, 1, 0, 0, 32'h0,          0, 7, 4);
        add(1, 16'h4444, 0, 0, 1, 0, 32'h0,          0, 8, 4);

        // Release reset mid-cycle with row 0 already applied: first pop at next edge.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Now in HALF with 4444 held: reset mid-cycle discards it.
        #2;
        rst = 1'b0;
        #1;
        chk("midrst valid", out_valid, 1'b0);
        chk("midrst pop", pop, 1'b0);
        chk("midrst words", words_popped, 16'h0);
        chk("midrst pkts", pkts_sent, 16'h0);
        chk("midrst data", out_data, 32'h0);
        @(negedge clk);
        pndng = 1'b0; flush = 1'b1; out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("postrst no partial", out_valid, 1'b0);
        pndng = 1'b1; Dout = 16'hCAFE; flush = 1'b0;
        #1;
        chk("postrst pop1", pop, 1'b1);
        @(posedge clk); #1;
        Dout = 16'hF00D;
        #1;
        chk("postrst pop2", pop, 1'b1);
        @(posedge clk); #1;
        pndng = 1'b0;
        chk("postrst valid", out_valid, 1'b1);
        chk("postrst data", out_data, 32'hF00DCAFE);
        chk("postrst partial", out_partial, 1'b0);
        chk("postrst words", words_popped, 16'h2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("postrst pkts", pkts_sent, 16'h1);

`ifdef PACKER_PARITY_EN
        for (int k = 0; k < 2; k++) begin
            logic [15:0] w;
            w = (k == 0) ? 16'h0007 : 16'h0003;
            out_ready = 1'b0; pndng = 1'b1; Dout = w; flush = 1'b0;
            @(posedge clk); #1;
            pndng = 1'b0; flush = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("par%0d data", k), out_data, {16'h0, w});
            chk($sformatf("par%0d parity", k), out_parity, (k == 0) ? 1'b1 : 1'b0);
            flush = 1'b0; out_ready = 1'b1;
            @(posedge clk); #1;
        end
`endif

        // Randomized phase: fresh reset so model and DUT start aligned.
        pndng = 1'b0; flush = 1'b0; out_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        m_valid = 1'b0; m_partial = 1'b0; m_data = '0; m_words = '0; m_pkts = '0;
        held.delete(); fq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int push_odds;
            logic exp_pop;
            // Alternate between bursty and sparse traffic so flushes hit HALF.
            push_odds = ((cyc / 200) % 2 == 0) ? 3 : 12;
            if (fq.size() < 8 && $urandom_range(0, push_odds) == 0) fq.push_back(16'($urandom));
            if (fq.size() < 8 && (cyc / 200) % 2 == 0 && $urandom_range(0, 1) == 0)
                fq.push_back(16'($urandom));
            flush     = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            pndng     = (fq.size() > 0);
            Dout      = pndng ? fq[0] : 16'($urandom);
            #1;
            exp_pop = pndng && !m_valid;
            chk("rand pop", pop, exp_pop);
            if (m_valid) begin
                if (out_ready) begin m_valid = 1'b0; m_pkts = m_pkts + 16'd1; end
            end else if (pndng) begin
                held.push_back(fq.pop_front());
                m_words = m_words + 16'd1;
                if (held.size() == 2) begin
                    m_data = {held[1], held[0]}; m_partial = 1'b0; m_valid = 1'b1;
                    held.delete();
                end
            end else if (flush && held.size() == 1) begin
                m_data = {16'h0, held[0]}; m_partial = 1'b1; m_valid = 1'b1;
                held.delete();
            end
            @(posedge clk); #1;
            chk("rand valid", out_valid, m_valid);
            if (m_valid) begin
                chk("rand data", out_data, m_data);
                chk("rand partial", out_partial, m_partial);
`ifdef PACKER_PARITY_EN
                chk("rand parity", out_parity, ^m_data);
`endif
            end
            chk("rand words", words_popped, m_words);
            chk("rand pkts", pkts_sent, m_pkts);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
